// File: rtl/byte_logic_sequencer_if.sv
// Request/response bundle between a requester and byte_logic_sequencer.
interface byte_logic_sequencer_if #(
  parameter int NBYTES = 4,
  parameter int SW     = $clog2(8*NBYTES)
);
  localparam int W = 8*NBYTES;

  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [SW-1:0] req_shamt;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_data;
  logic          resp_carry;
  logic          resp_any;
  logic          resp_err;
  logic          busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_carry, resp_any, resp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_data, resp_carry, resp_any, resp_err, busy
  );
endinterface

// File: rtl/byte_logic_sequencer.sv
// Byte-serial logic sequencer: runs one 8-bit logic slice across an
// NBYTES-wide word, LSB byte first; multi-bit SHL is repeated 1-bit passes.
module byte_logic_sequencer #(
  parameter int NBYTES = 4,
  parameter int SW     = $clog2(8*NBYTES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  byte_logic_sequencer_if.slave   bus
);
  localparam int W  = 8*NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES-1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_ANY = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_op;
  logic [W-1:0]  r_a, r_b, r_res;
  logic [SW-1:0] r_shamt, r_pass;
  logic [IW-1:0] r_idx;
  logic          r_cin, r_carry, r_flag, r_err;

  logic          w_illegal_req, w_shl0_req, w_last_byte, w_last;
  logic [7:0]    w_a_byte, w_b_byte, w_res_byte, w_out_byte;

  assign w_illegal_req = (bus.req_op[2:1] == 2'b11);
  assign w_shl0_req    = (bus.req_op == OP_SHL) && (bus.req_shamt == '0);
  assign w_last_byte   = (r_idx == LAST_IDX);
  // SHL ends on the last byte of the final pass; everything else after one sweep
  assign w_last        = w_last_byte && ((r_op != OP_SHL) || (r_pass == r_shamt - SW'(1)));

  assign w_a_byte   = r_a  [{r_idx, 3'b000} +: 8];
  assign w_b_byte   = r_b  [{r_idx, 3'b000} +: 8];
  // SHL works in place on r_res, so the shift reads the working word
  assign w_res_byte = r_res[{r_idx, 3'b000} +: 8];

  // Byte-wide logic slice; r_cin carries the previous byte's original bit 7
  always_comb begin
    w_out_byte = 8'h00;
    case (r_op)
      OP_AND:  w_out_byte = w_a_byte & w_b_byte;
      OP_OR:   w_out_byte = w_a_byte | w_b_byte;
      OP_XOR:  w_out_byte = w_a_byte ^ w_b_byte;
      OP_NOT:  w_out_byte = ~w_a_byte;
      OP_SHL:  w_out_byte = {w_res_byte[6:0], (r_idx == '0) ? 1'b0 : r_cin};
      default: w_out_byte = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; illegal op and zero-shift skip RUN entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.req_valid)
                w_next = (w_illegal_req || w_shl0_req) ? S_RESP : S_RUN;
      S_RUN:  if (w_last) w_next = S_RESP;
      S_RESP: if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs; response fields are forced to 0 outside RESP
  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.resp_valid = (r_state == S_RESP);
    bus.busy       = (r_state != S_IDLE);
    bus.resp_data  = bus.resp_valid ? r_res : '0;
    bus.resp_carry = bus.resp_valid & r_carry;
    bus.resp_any   = bus.resp_valid & (|r_res);
    bus.resp_err   = bus.resp_valid & r_err;
  end

  // Operand latch and per-byte datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_shamt <= '0;
      r_pass  <= '0;
      r_idx   <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_flag  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_op    <= bus.req_op;
          r_a     <= bus.req_a;
          r_b     <= bus.req_b;
          r_shamt <= bus.req_shamt;
          r_pass  <= '0;
          r_idx   <= '0;
          r_cin   <= 1'b0;
          r_carry <= 1'b0;
          r_flag  <= 1'b0;
          r_err   <= w_illegal_req;
          // SHL shifts A in place (also the shamt=0 result); others build from 0
          r_res   <= (bus.req_op == OP_SHL) ? bus.req_a : '0;
        end
        S_RUN: begin
          r_idx <= w_last_byte ? '0 : r_idx + 1'b1;
          if (r_op == OP_ANY) begin
            r_flag <= r_flag | (|w_a_byte);
            if (w_last_byte) r_res <= {{(W-1){1'b0}}, r_flag | (|w_a_byte)};
          end else begin
            r_res[{r_idx, 3'b000} +: 8] <= w_out_byte;
          end
          if (r_op == OP_SHL) begin
            r_cin <= w_res_byte[7];
            if (w_last_byte) begin
              r_carry <= w_res_byte[7];
              r_pass  <= r_pass + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_logic_sequencer.sv
// Bench for byte_logic_sequencer: directed vector table, reset-abort
// sequence and randomized transactions against a word-level model.
module tb_byte_logic_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  byte_logic_sequencer_if #(.NBYTES(4)) bus ();

  byte_logic_sequencer #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] d;
    logic        c;
    logic        e;
    int          lat;
    int          bp;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Word-level reference: whole-word operators, shift via <<, latency from op rules
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] d, output logic c,
                       output logic e, output int lat);
    d = '0; c = 1'b0; e = 1'b0; lat = 5;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: d = a ^ b;
      3'd3: d = ~a;
      3'd4: begin
        d   = a << sh;
        c   = (sh == 0) ? 1'b0 : a[32 - int'(sh)];
        lat = int'(sh) * 4 + 1;
      end
      3'd5: d = {31'b0, |a};
      default: begin e = 1'b1; lat = 1; end
    endcase
  endtask

  // One full transaction: accept, latency count, backpressure hold, release
  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] ed, input logic ec,
                         input logic ee, input int elat, input int bp);
    int  lat;
    bit  got;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_shamt = sh;
    @(negedge clk);
    chk("req_ready_idle", {63'b0, bus.req_ready}, 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a = ~a; bus.req_b = ~b;
    lat = 0; got = 0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy_after_accept", {63'b0, bus.busy}, 64'd1);
      if (bus.resp_valid) got = 1;
      else @(posedge clk);
    end
    if (!got) begin
      chk("resp_timeout", 64'd0, 64'd1);
      return;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("resp_data", {32'b0, bus.resp_data}, {32'b0, ed});
    chk("resp_carry", {63'b0, bus.resp_carry}, {63'b0, ec});
    chk("resp_any", {63'b0, bus.resp_any}, {63'b0, |ed});
    chk("resp_err", {63'b0, bus.resp_err}, {63'b0, ee});
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = $urandom; bus.req_b = $urandom;
      @(negedge clk);
      chk("bp_valid", {63'b0, bus.resp_valid}, 64'd1);
      chk("bp_data", {32'b0, bus.resp_data}, {32'b0, ed});
      chk("bp_req_ready", {63'b0, bus.req_ready}, 64'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {63'b0, bus.req_ready}, 64'd1);
    chk("idle_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb, rd;
    logic [4:0]  rsh;
    logic        rc, re;
    int          rlat;
    bit          seen;

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_shamt = '0; bus.resp_ready = 1'b0;

    vt[0]  = '{3'd0, 32'hF0F01234, 32'h0FF0FF00, 5'd0,  32'h00F01200, 1'b0, 1'b0, 5,   0};
    vt[1]  = '{3'd4, 32'hE0000000, 32'h0,        5'd3,  32'h00000000, 1'b1, 1'b0, 13,  0};
    vt[2]  = '{3'd4, 32'h80000001, 32'h0,        5'd1,  32'h00000002, 1'b1, 1'b0, 5,   0};
    vt[3]  = '{3'd5, 32'h00000000, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0, 1'b0, 5,   0};
    vt[4]  = '{3'd5, 32'h00010000, 32'h0,        5'd0,  32'h00000001, 1'b0, 1'b0, 5,   0};
    vt[5]  = '{3'd3, 32'h00FF00FF, 32'h12345678, 5'd0,  32'hFF00FF00, 1'b0, 1'b0, 5,   0};
    vt[6]  = '{3'd2, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd0,  32'h55555555, 1'b0, 1'b0, 5,   3};
    vt[7]  = '{3'd6, 32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h00000000, 1'b0, 1'b1, 1,   0};
    vt[8]  = '{3'd4, 32'h12345678, 32'h0,        5'd0,  32'h12345678, 1'b0, 1'b0, 1,   0};
    vt[9]  = '{3'd1, 32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b0, 1'b0, 5,   1};
    vt[10] = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 1'b0, 1'b1, 1,   2};
    vt[11] = '{3'd4, 32'h00000001, 32'h0,        5'd31, 32'h80000000, 1'b0, 1'b0, 125, 0};
    vt[12] = '{3'd4, 32'hFFFFFFFF, 32'h0,        5'd31, 32'h80000000, 1'b1, 1'b0, 125, 0};
    vt[13] = '{3'd4, 32'h12345678, 32'h0,        5'd4,  32'h23456780, 1'b1, 1'b0, 17,  0};
    vt[14] = '{3'd4, 32'h01234567, 32'h0,        5'd8,  32'h23456700, 1'b1, 1'b0, 33,  1};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'b0, bus.req_ready}, 64'd1);
    chk("rst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_outputs", {32'b0, bus.resp_data, 29'b0, bus.resp_carry, bus.resp_any, bus.resp_err}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_txn(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, vt[i].d, vt[i].c, vt[i].e, vt[i].lat, vt[i].bp);

    // reset during the 6th RUN cycle of a 4-pass shift drops the request
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 32'hDEADBEEF; bus.req_shamt = 5'd4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", {63'b0, bus.req_ready}, 64'd1);
    chk("abort_busy", {63'b0, bus.busy}, 64'd0);
    bus.resp_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1;
    end
    bus.resp_ready = 1'b0;
    chk("abort_no_resp", {63'b0, seen}, 64'd0);
    run_txn(3'd0, 32'hF0F01234, 32'h0FF0FF00, 5'd0, 32'h00F01200, 1'b0, 1'b0, 5, 0);

    // randomized transactions against the word-level model
    for (int k = 0; k < 150; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      rsh = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = ra & {4{8'($urandom_range(0, 1))}};
      model(rop, ra, rb, rsh, rd, rc, re, rlat);
      run_txn(rop, ra, rb, rsh, rd, rc, re, rlat, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
